// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Values for the MSB_FIRST parameter.
    localparam bit MSB_SEL = 1'b1;
    localparam bit LSB_SEL = 1'b0;

    // Bit counter width: enough to count 0 .. width-1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register that lets the next word wait while the current one shifts.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full
);

    logic [WIDTH-1:0] hold;
    logic             hold_full;

    // wr only happens when empty and rd only when full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (rd) begin
                hold_full <= 1'b0;
            end
            if (wr) begin
                hold      <= wdata;
                hold_full <= 1'b1;
            end
        end
    end

    assign rdata = hold;
    assign full  = hold_full;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer for gapless streaming.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = MSB_SEL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sframe,
    output logic             done,
    output logic             busy
);

    localparam int           CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             xfer;
    logic             last_bit;
    logic             hold_wr;
    logic             hold_rd;

    assign din_ready = !hold_full;
    assign xfer      = din_valid && din_ready;
    assign last_bit  = (state == SHIFT) && (cnt == LAST);

    // A word arriving on the last-bit edge with the buffer empty bypasses it.
    assign hold_wr = xfer && (state == SHIFT) && !last_bit;
    assign hold_rd = last_bit && hold_full;

    always_comb begin
        shifted = '0;
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (hold_wr),
        .rd    (hold_rd),
        .wdata (din),
        .rdata (hold),
        .full  (hold_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_bit;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state <= SHIFT;
                        shreg <= din;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (hold_full) begin
                            shreg <= hold;
                        end else if (xfer) begin
                            shreg <= din;
                        end else begin
                            state <= IDLE;
                            shreg <= '0;
                        end
                    end else begin
                        shreg <= shifted;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    shreg <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign sframe = (state == SHIFT);
    assign sout   = sframe & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign busy   = sframe | hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Directed and randomized checks of piso_tx in MSB-first and LSB-first builds.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;
    logic       din_ready, sout, sframe, done, busy;
    logic [3:0] din2 = 4'h0;
    logic       din_valid2 = 1'b0;
    logic       din_ready2, sout2, sframe2, done2, busy2;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sout(sout), .sframe(sframe), .done(done), .busy(busy)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(din_valid2),
        .din_ready(din_ready2), .sout(sout2), .sframe(sframe2), .done(done2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b0;
        din_valid = 1'b0;
        din_valid2 = 1'b0;
        repeat (2) step();
        got = {sout, sframe, done, busy, din_ready, sout2, sframe2, done2, busy2, din_ready2};
        vec_cnt++;
        if (got !== 10'b00001_00001) begin
            miscompare_cnt++;
            $display("FAIL reset_outputs: got %b want %b", got, 10'b00001_00001);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_msb();
        logic [3:0] pat = 4'b1000;
        din = pat;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if ({sframe, sout, done} !== {1'b1, pat[3-i], 1'b0}) begin
                miscompare_cnt++;
                $display("FAIL single_bit%0d: got sframe/sout/done %b want %b", i,
                         {sframe, sout, done}, {1'b1, pat[3-i], 1'b0});
            end
            step();
        end
        vec_cnt++;
        if ({done, sframe, busy, sout} !== 4'b1000) begin
            miscompare_cnt++;
            $display("FAIL single_done: got done/sframe/busy/sout %b want 1000",
                     {done, sframe, busy, sout});
        end
        step();
        vec_cnt++;
        if ({done, busy} !== 2'b00) begin
            miscompare_cnt++;
            $display("FAIL single_after: got done/busy %b want 00", {done, busy});
        end
    endtask

    task automatic test_single_lsb();
        logic [3:0] exp_bits = 4'b1000;
        din2 = 4'b0001;
        din_valid2 = 1'b1;
        step();
        din_valid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if ({sframe2, sout2} !== {1'b1, exp_bits[3-i]}) begin
                miscompare_cnt++;
                $display("FAIL lsb_bit%0d: got sframe/sout %b want %b", i,
                         {sframe2, sout2}, {1'b1, exp_bits[3-i]});
            end
            step();
        end
        vec_cnt++;
        if ({done2, sframe2} !== 2'b10) begin
            miscompare_cnt++;
            $display("FAIL lsb_done: got done/sframe %b want 10", {done2, sframe2});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  words [3] = '{4'b1000, 4'b0101, 4'b1111};
        logic [11:0] exp_bits = 12'b1000_0101_1111;
        int          idx = 0;
        logic        xfer;
        for (int c = 0; c <= 13; c++) begin
            if (c >= 1 && c <= 12) begin
                vec_cnt++;
                if ({sframe, sout} !== {1'b1, exp_bits[12-c]}) begin
                    miscompare_cnt++;
                    $display("FAIL b2b_bit_c%0d: got sframe/sout %b want %b", c,
                             {sframe, sout}, {1'b1, exp_bits[12-c]});
                end
            end
            if (c == 13) begin
                vec_cnt++;
                if (sframe !== 1'b0) begin
                    miscompare_cnt++;
                    $display("FAIL b2b_end_sframe: got %b want 0", sframe);
                end
            end
            if (c >= 1) begin
                vec_cnt++;
                if (done !== (c == 5 || c == 9 || c == 13)) begin
                    miscompare_cnt++;
                    $display("FAIL b2b_done_c%0d: got %b want %b", c, done,
                             (c == 5 || c == 9 || c == 13));
                end
            end
            if (c == 2 || c == 5 || c == 6) begin
                vec_cnt++;
                if (din_ready !== (c == 5)) begin
                    miscompare_cnt++;
                    $display("FAIL b2b_ready_c%0d: got %b want %b", c, din_ready, (c == 5));
                end
            end
            if (idx < 3) begin
                din = words[idx];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            xfer = din_valid && din_ready;
            step();
            if (xfer) idx++;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_last_edge_xfer();
        logic [7:0] exp_bits = 8'b1010_0110;
        for (int c = 0; c <= 9; c++) begin
            if (c >= 1 && c <= 8) begin
                vec_cnt++;
                if ({sframe, sout} !== {1'b1, exp_bits[8-c]}) begin
                    miscompare_cnt++;
                    $display("FAIL lastedge_bit_c%0d: got sframe/sout %b want %b", c,
                             {sframe, sout}, {1'b1, exp_bits[8-c]});
                end
            end
            if (c == 5 || c == 9) begin
                vec_cnt++;
                if ({done, sframe} !== {1'b1, (c == 5)}) begin
                    miscompare_cnt++;
                    $display("FAIL lastedge_done_c%0d: got done/sframe %b want %b", c,
                             {done, sframe}, {1'b1, (c == 5)});
                end
            end
            din_valid = (c == 0 || c == 4);
            din = (c == 0) ? 4'b1010 : 4'b0110;
            step();
        end
        din_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_frame();
        din = 4'b1010;
        din_valid = 1'b1;
        step();
        din = 4'b0011;
        step();
        din_valid = 1'b0;
        vec_cnt++;
        if ({sframe, sout, busy, din_ready} !== 4'b1010) begin
            miscompare_cnt++;
            $display("FAIL rstmid_pre: got sframe/sout/busy/ready %b want 1010",
                     {sframe, sout, busy, din_ready});
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({sframe, sout, busy, din_ready, done} !== 5'b00010) begin
            miscompare_cnt++;
            $display("FAIL rstmid_async: got sframe/sout/busy/ready/done %b want 00010",
                     {sframe, sout, busy, din_ready, done});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            vec_cnt++;
            if ({sframe, sout, busy, done} !== 4'b0000) begin
                miscompare_cnt++;
                $display("FAIL rstmid_after_c%0d: got sframe/sout/busy/done %b want 0000", c,
                         {sframe, sout, busy, done});
            end
            step();
        end
    endtask

    task automatic test_random_stream();
        logic [3:0] exp_q[$];
        logic [3:0] acc = 4'h0;
        logic [3:0] exp_w;
        int         nbits = 0;
        int         sent = 0;
        int         rcv = 0;
        int         cyc = 0;
        logic       xfer;
        while (rcv < 1000 && cyc < 30000) begin
            if (sframe) begin
                acc = {acc[2:0], sout};
                nbits++;
                if (nbits == 4) begin
                    nbits = 0;
                    rcv++;
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : ~acc;
                    vec_cnt++;
                    if (acc !== exp_w) begin
                        miscompare_cnt++;
                        $display("FAIL rand_word%0d: got %b want %b", rcv, acc, exp_w);
                    end
                end
            end else if (sout !== 1'b0) begin
                vec_cnt++;
                miscompare_cnt++;
                $display("FAIL rand_sout_gate: got %b want 0", sout);
            end
            if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                din = 4'($urandom_range(0, 15));
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            xfer = din_valid && din_ready;
            step();
            cyc++;
            if (xfer) begin
                exp_q.push_back(din);
                sent++;
            end
        end
        din_valid = 1'b0;
        vec_cnt++;
        if (rcv != 1000 || exp_q.size() != 0) begin
            miscompare_cnt++;
            $display("FAIL rand_complete: got %0d words (%0d pending) want 1000 (0 pending)",
                     rcv, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_single_lsb();
        test_back_to_back();
        step();
        test_last_edge_xfer();
        test_reset_mid_frame();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
